// File: rtl/mic_translator.sv
// I2S microphone front end: generates BCLK/LRCLK, collects 16 ten-bit samples
// from one slot and publishes them as a frame. Macro MIC_TRANSLATOR_RIGHT_CH_EN selects the right slot.
module mic_translator (
  input  logic       clk,
  input  logic       reset,
  input  logic       DOUT,
  output logic       LRCLK,
  output logic       BCLK,
  output logic       new_t,
  output logic [9:0] t0,
  output logic [9:0] t1,
  output logic [9:0] t2,
  output logic [9:0] t3,
  output logic [9:0] t4,
  output logic [9:0] t5,
  output logic [9:0] t6,
  output logic [9:0] t7,
  output logic [9:0] t8,
  output logic [9:0] t9,
  output logic [9:0] t10,
  output logic [9:0] t11,
  output logic [9:0] t12,
  output logic [9:0] t13,
  output logic [9:0] t14,
  output logic [9:0] t15
);

`ifdef MIC_TRANSLATOR_RIGHT_CH_EN
  localparam logic SEL_SLOT = 1'b1;
`else
  localparam logic SEL_SLOT = 1'b0;
`endif

  logic [7:0]  cnt_q;
  logic [22:0] shreg_q;
  logic [3:0]  k_q;
  logic        xfer_q;
  logic        new_t_q;
  logic [9:0]  buf_q [16];
  logic [9:0]  t_q   [16];

  logic [4:0]  bit_idx;
  logic        capture;
  logic        last_bit;
  logic        write_en;
  logic [9:0]  sample_d;

  // Capture on the BCLK rising edge (cnt 4s+1 -> 4s+2) inside the data bits of the chosen slot.
  assign bit_idx  = cnt_q[6:2];
  assign capture  = (cnt_q[1:0] == 2'b01) && (cnt_q[7] == SEL_SLOT) &&
                    (bit_idx >= 5'd1) && (bit_idx <= 5'd24);
  assign last_bit = (bit_idx == 5'd24);
  assign write_en = capture && last_bit;
  // The 24th bit is the LSB, so word[23:14] is already sitting in the shift register.
  assign sample_d = shreg_q[22:13];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 8'd0;
      shreg_q <= 23'd0;
      k_q     <= 4'd0;
      xfer_q  <= 1'b0;
      new_t_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 8'd1;
      new_t_q <= xfer_q;
      xfer_q  <= write_en && (k_q == 4'd15);
      if (capture) begin
        shreg_q <= {shreg_q[21:0], DOUT};
      end
      if (write_en) begin
        k_q <= k_q + 4'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          buf_q[gi] <= 10'd0;
          t_q[gi]   <= 10'd0;
        end else begin
          if (write_en && (k_q == 4'(gi))) begin
            buf_q[gi] <= sample_d;
          end
          if (xfer_q) begin
            t_q[gi] <= buf_q[gi];
          end
        end
      end
    end
  endgenerate

  assign BCLK  = cnt_q[1];
  assign LRCLK = cnt_q[7];
  assign new_t = new_t_q;
  assign t0  = t_q[0];
  assign t1  = t_q[1];
  assign t2  = t_q[2];
  assign t3  = t_q[3];
  assign t4  = t_q[4];
  assign t5  = t_q[5];
  assign t6  = t_q[6];
  assign t7  = t_q[7];
  assign t8  = t_q[8];
  assign t9  = t_q[9];
  assign t10 = t_q[10];
  assign t11 = t_q[11];
  assign t12 = t_q[12];
  assign t13 = t_q[13];
  assign t14 = t_q[14];
  assign t15 = t_q[15];

endmodule

// File: tb/tb_mic_translator.sv
// Scoreboard bench for mic_translator: an I2S mic model drives DOUT, expected frames
// are queued by the stimulus and checked by a monitor whenever new_t pulses.
module tb_mic_translator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       DOUT = 1'b0;
  logic       LRCLK;
  logic       BCLK;
  logic       new_t;
  logic [9:0] t_w [16];

`ifdef MIC_TRANSLATOR_RIGHT_CH_EN
  localparam logic SEL = 1'b1;
  localparam int   OFS = 128;
`else
  localparam logic SEL = 1'b0;
  localparam int   OFS = 0;
`endif
  localparam int FIRST = 3939 + OFS;

  always #5 clk = ~clk;

  mic_translator dut (
    .clk(clk), .reset(reset), .DOUT(DOUT), .LRCLK(LRCLK), .BCLK(BCLK), .new_t(new_t),
    .t0(t_w[0]),   .t1(t_w[1]),   .t2(t_w[2]),   .t3(t_w[3]),
    .t4(t_w[4]),   .t5(t_w[5]),   .t6(t_w[6]),   .t7(t_w[7]),
    .t8(t_w[8]),   .t9(t_w[9]),   .t10(t_w[10]), .t11(t_w[11]),
    .t12(t_w[12]), .t13(t_w[13]), .t14(t_w[14]), .t15(t_w[15])
  );

  typedef struct {
    int         edge_no;
    logic [9:0] v [16];
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     mode = 0;
  int     edge_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // Selected-slot word for sample number n under the current mode
  function automatic logic [23:0] word_for(input int n);
    logic [9:0] val;
    if (mode == 1) return 24'h7FC000 + 24'(n % 16);
    val = 10'(n % 16) | (((n / 16) % 2 == 1) ? 10'h200 : 10'h000);
    return {val, 14'h2AAA};
  endfunction

  // Microphone model: updates DOUT just after each BCLK falling edge
  int   mic_idx;
  int   sel_cnt;
  logic prev_lr;
  logic prev_bclk;
  always @(posedge clk) begin
    logic [23:0] w;
    #1;
    if (reset) begin
      mic_idx   = 0;
      sel_cnt   = 0;
      prev_lr   = 1'b0;
      prev_bclk = 1'b0;
      DOUT      = (mode == 0);
    end else begin
      if (prev_bclk && !BCLK) begin
        if (LRCLK != prev_lr) begin
          if (prev_lr == SEL) sel_cnt++;
          mic_idx = 0;
        end else begin
          mic_idx++;
        end
        if (mode == 0) begin
          DOUT = 1'b1;
        end else if (mic_idx < 1 || mic_idx > 24) begin
          DOUT = 1'b0;
        end else begin
          w = (LRCLK == SEL) ? word_for(sel_cnt) : 24'h800000;
          DOUT = w[24 - mic_idx];
        end
      end
      prev_bclk = BCLK;
      prev_lr   = LRCLK;
    end
  end

  // Monitor: every new_t pulse must match the head of the expectation queue
  always @(negedge clk) begin
    frame_t e;
    if (new_t === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_new_t", 32'(new_t), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("new_t_edge", 32'(edge_cnt), 32'(e.edge_no));
        for (int i = 0; i < 16; i++) chk($sformatf("t%0d", i), 32'(t_w[i]), 32'(e.v[i]));
        $display("frame at edge %0d: t0=%0h t15=%0h", edge_cnt, t_w[0], t_w[15]);
      end
    end
  end

  task automatic start(input int m);
    @(negedge clk);
    reset = 1'b1;
    mode  = m;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_frame(input int edge_no, input int m, input int f);
    frame_t e;
    e.edge_no = edge_no;
    for (int i = 0; i < 16; i++) begin
      if (m == 0)      e.v[i] = 10'h3FF;
      else if (m == 1) e.v[i] = 10'h1FF;
      else             e.v[i] = 10'(i) | ((f % 2 == 1) ? 10'h200 : 10'h000);
    end
    exp_q.push_back(e);
  endtask

  task automatic check_all_t(input string name, input logic [9:0] v);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_t%0d", name, i), 32'(t_w[i]), 32'(v));
  endtask

  initial begin
    logic [31:0] n;
    // Reset state and clock generation
    repeat (2) @(negedge clk);
    chk("rst_bclk", 32'(BCLK), 32'd0);
    chk("rst_lrclk", 32'(LRCLK), 32'd0);
    chk("rst_new_t", 32'(new_t), 32'd0);
    check_all_t("rst", 10'h000);
    reset = 1'b0;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      n = 32'(e);
      chk("bclk_phase", 32'(BCLK), 32'(n[1]));
      chk("lrclk_phase", 32'(LRCLK), 32'(n[7]));
    end
    $display("clock phase sweep done");

    // DOUT held 1 for 4200 cycles
    start(0);
    push_frame(FIRST, 0, 0);
    repeat (4200) @(negedge clk);
    chk("ones_missing_frame", 32'(exp_q.size()), 32'd0);
    check_all_t("ones_hold", 10'h3FF);

    // Reset after one LRCLK frame discards partial data
    start(0);
    repeat (256) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_bclk", 32'(BCLK), 32'd0);
    chk("midrst_lrclk", 32'(LRCLK), 32'd0);
    check_all_t("midrst", 10'h000);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check_all_t("midrst_after", 10'h000);
    $display("mid-frame reset done");

    // Selected slot near max positive, other slot most negative
    start(1);
    push_frame(FIRST, 1, 0);
    repeat (FIRST + 20) @(negedge clk);
    chk("slot_missing_frame", 32'(exp_q.size()), 32'd0);

    // Ramp 0..15 then negative ramp in the second frame
    start(2);
    push_frame(FIRST, 2, 0);
    push_frame(FIRST + 4096, 2, 1);
    repeat (FIRST + 4096 + 20) @(negedge clk);
    chk("ramp_missing_frame", 32'(exp_q.size()), 32'd0);
    chk("ramp_hold_t0", 32'(t_w[0]), 32'h200);
    chk("ramp_hold_t15", 32'(t_w[15]), 32'h20F);

    // Reset coinciding with the frame transfer edge
    start(2);
    repeat (FIRST - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("xfer_rst_new_t", 32'(new_t), 32'd0);
    check_all_t("xfer_rst", 10'h000);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("xfer_rst_after_new_t", 32'(new_t), 32'd0);
    check_all_t("xfer_rst_after", 10'h000);
    $display("transfer-edge reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_translator.md
MIC_TRANSLATOR -- requirements
Module: mic_translator

Interface
REQ-001 clk  input  1  system clock; every register updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 DOUT  input  1  I2S serial data from the microphone, MSB first, driven by the mic on BCLK falling edges.
REQ-004 LRCLK  output  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-005 BCLK  output  1  I2S bit clock generated from clk.
REQ-006 new_t  output  1  one-clk-cycle pulse: t0..t15 have just been loaded with a new frame.
REQ-007 t0..t15  output  10 each  frame of 16 consecutive 10-bit samples; t0 oldest, t15 newest.

Function
REQ-008 An 8-bit free-running counter cnt SHALL increment by 1 every clk cycle and wrap from 255 to 0.
REQ-009 BCLK SHALL equal cnt[1] (clk/4); LRCLK SHALL equal cnt[7] (32 BCLK periods per slot, 256 clk per LRCLK frame); both SHALL be registered, glitch-free and derived only from cnt.
REQ-010 Slot bit index SHALL be cnt[6:2] (0..31); a DOUT bit SHALL be captured at the clk edge where cnt changes from 4s+1 to 4s+2 (BCLK rising), within the selected slot.
REQ-011 Standard I2S one-bit delay: slot index 1 carries the MSB; indices 1..24 form a 24-bit two's-complement word; index 0 and indices 25..31 SHALL be ignored.
REQ-012 On capture of index 24, the sample value SHALL be word[23:14] (top 10 bits, two's complement, no rounding), written into internal buffer entry k, where k is a 4-bit sample counter; k then increments and wraps 15->0.
REQ-013 When entry 15 is written, on the next clk edge all 16 buffer entries SHALL be copied to t0..t15 simultaneously (entry 0 -> t0) and new_t SHALL be 1 for exactly that one cycle.
REQ-014 t0..t15 SHALL hold their value between transfers; new_t SHALL be 0 in all other cycles.
REQ-015 One frame = 16 LRCLK periods = 4096 clk cycles; after reset release, the first new_t SHALL be high in the cycle following the 3939th rising clk edge with reset low, and every 4096 cycles thereafter.
REQ-016 The unselected slot's data SHALL never affect any output.

Reset
REQ-017 While reset = 1: cnt = 0, BCLK = 0, LRCLK = 0, new_t = 0, t0..t15 = 0, all buffer entries = 0, capture shift register = 0, k = 0.
REQ-018 Reset asserted mid-frame or mid-word SHALL discard all partial data; no new_t SHALL be produced for that frame.
REQ-019 Reset has priority over every other event in the same cycle, including a pending frame transfer.

Configuration
REQ-020 Macro MIC_TRANSLATOR_RIGHT_CH_EN: when defined, capture SHALL occur in the right slot (LRCLK = 1, cnt[7] = 1); when undefined, in the left slot (LRCLK = 0). Timing in REQ-015 then shifts by +128 cycles (first new_t after edge 4067).

Verification
REQ-021 Reset held 1 cycle -> BCLK = LRCLK = new_t = 0, all t = 0; after release BCLK toggles every 2 clk, LRCLK every 128 clk.
REQ-022 DOUT held 1, run 4200 cycles -> single new_t pulse after edge 3939; all t0..t15 = 10'h3FF afterwards.
REQ-023 DOUT held 1, run 256 cycles (one LRCLK frame), then assert reset -> no new_t, all t remain 0, counters return to 0.
REQ-024 Left slot drives sample i = 24'h7FC000 + i, right slot drives 24'h800000 -> t0..t15 all = 10'h1FF, right data never appears.
REQ-025 Left word sequence with top bits 0,1,...,15 -> t0 = 0 ... t15 = 15 (10-bit); next frame with new data updates all 16 together on a single new_t.
REQ-026 Reset asserted in the same cycle as the frame transfer -> new_t stays 0, all t = 0.
